// File: rtl/user_uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of a baud-timed shifter.
// Queued bytes go out back-to-back with no idle cycles between frames.
module user_uart_tx #(
  parameter int CLKS_PER_BIT = 4167,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_o,
  output logic       tx_oeb,
  output logic       busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state_reg, state_next;
  logic [BW-1:0]  baud_reg, baud_next;
  logic [2:0]     bit_reg, bit_next;
  logic [7:0]     shift_reg, shift_next;
  logic [CW-1:0]  count_reg;
  logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [7:0]     mem [FIFO_DEPTH];
  logic           tx_reg, tx_next;
  logic           busy_reg, oeb_reg;
  logic           push, pop, bit_end, has_data;

  assign tx_ready = (count_reg != CW'(FIFO_DEPTH));
  assign push     = tx_valid & tx_ready;
  assign has_data = (count_reg != '0);
  assign bit_end  = (baud_reg == BW'(CLKS_PER_BIT - 1));

  assign tx_o   = tx_reg;
  assign tx_oeb = oeb_reg;
  assign busy   = busy_reg;

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg + 1'b1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    pop        = 1'b0;
    tx_next    = 1'b1;
    case (state_reg)
      IDLE: begin
        baud_next = '0;
        if (has_data) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr_reg];
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_end) begin
          baud_next  = '0;
          bit_next   = 3'd0;
          state_next = DATA;
        end
      end
      DATA: begin
        tx_next = shift_reg[0];
        if (bit_end) begin
          baud_next  = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_reg == 3'd7) state_next = STOP;
          else                 bit_next   = bit_reg + 3'd1;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          baud_next = '0;
          // Chain straight into the next start bit when more bytes are queued.
          if (has_data) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr_reg];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (push && !wb_rst_i) mem[wr_ptr_reg] <= tx_data;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg  <= IDLE;
      baud_reg   <= '0;
      bit_reg    <= 3'd0;
      shift_reg  <= 8'd0;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      tx_reg     <= 1'b1;
      busy_reg   <= 1'b0;
      oeb_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      oeb_reg   <= 1'b0;
      // Registered so busy drops on the same edge the stop bit ends on the line.
      busy_reg  <= (state_reg != IDLE) | has_data;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_user_uart_tx.sv
// Bench for user_uart_tx: line receiver plus a frame-timing model
// (frame k starts at max(accept_k + 2, start_{k-1} + 10*bit_time)).
module tb_user_uart_tx;

  localparam int C8 = 8;
  localparam int CD = 4167;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_o, tx_oeb, busy;
  logic [7:0] d_data = 8'd0;
  logic       d_valid = 1'b0;
  logic       d_ready, d_tx_o, d_tx_oeb, d_busy;

  int num_checks = 0;
  int num_errors = 0;
  int cyc = 0;
  int prev_start = -1000000;

  logic [7:0] exp_byte_q[$];
  int         exp_acc_q[$];
  logic [7:0] rx_byte_q[$];
  int         rx_start_q[$];

  user_uart_tx #(.CLKS_PER_BIT(C8), .FIFO_DEPTH(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_o(tx_o), .tx_oeb(tx_oeb), .busy(busy)
  );

  user_uart_tx dut_d (
    .wb_clk_i(clk), .wb_rst_i(rst), .tx_data(d_data), .tx_valid(d_valid),
    .tx_ready(d_ready), .tx_o(d_tx_o), .tx_oeb(d_tx_oeb), .busy(d_busy)
  );

  always #12.5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int t, input int c);
    int k;
    k = t / c;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Receiver on the C8 instance: every bit must hold its level for exactly C8 cycles.
  initial begin : rx_monitor
    logic [7:0] rb;
    logic lvl;
    int st;
    bit ok, aborted;
    @(negedge clk);
    forever begin
      if (tx_oeb === 1'b0 && tx_o === 1'b0) begin
        st = cyc; ok = 1; aborted = 0; rb = 8'd0; lvl = 1'b0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int k = 0; k < C8 && !aborted; k++) begin
            if (tx_oeb !== 1'b0) aborted = 1;
            else begin
              if (k == 0) lvl = tx_o;
              else if (tx_o !== lvl) ok = 0;
              @(negedge clk);
            end
          end
          if (!aborted) begin
            if (b == 0 && lvl !== 1'b0) ok = 0;
            if (b >= 1 && b <= 8) rb[b-1] = lvl;
            if (b == 9 && lvl !== 1'b1) ok = 0;
          end
        end
        if (!aborted) begin
          check("rx_frame_ok", 32'(ok), 32'd1);
          rx_byte_q.push_back(rb);
          rx_start_q.push_back(st);
        end else @(negedge clk);
      end else @(negedge clk);
    end
  end

  task automatic push8(input logic [7:0] b, output int acc);
    int waited = 0;
    tx_data = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && waited < 2000) begin @(negedge clk); waited++; end
    acc = -1;
    if (tx_ready !== 1'b1) begin
      check("push_ready_timeout", 32'(tx_ready), 32'd1);
      tx_valid = 1'b0;
    end else begin
      @(negedge clk);
      acc = cyc;
      exp_byte_q.push_back(b);
      exp_acc_q.push_back(acc);
      tx_valid = 1'b0;
    end
  endtask

  task automatic drain(input int n);
    int waited = 0;
    logic [7:0] gb, eb;
    int gs, ea, es;
    while (rx_byte_q.size() < n && waited < n * 10 * C8 + 400) begin @(negedge clk); waited++; end
    check("rx_count", 32'(rx_byte_q.size()), 32'(n));
    while (rx_byte_q.size() > 0 && exp_byte_q.size() > 0) begin
      gb = rx_byte_q.pop_front();  gs = rx_start_q.pop_front();
      eb = exp_byte_q.pop_front(); ea = exp_acc_q.pop_front();
      es = (ea + 2 > prev_start + 10 * C8) ? ea + 2 : prev_start + 10 * C8;
      prev_start = es;
      $display("rx byte %02h start cycle %0d (accepted %0d)", gb, gs, ea);
      check("rx_byte", 32'(gb), 32'(eb));
      check("rx_start", 32'(gs), 32'(es));
    end
  endtask

  initial begin : watchdog
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int acc, n0, acc11, lows, mism, target;
    logic [7:0] burst [5];
    burst[0] = 8'hA5; burst[1] = 8'h5A; burst[2] = 8'h00; burst[3] = 8'hFF; burst[4] = 8'h3C;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_tx_o", 32'(tx_o), 32'd1);
    check("rst_oeb", 32'(tx_oeb), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_oeb", 32'(tx_oeb), 32'd0);
    check("post_rst_tx_o", 32'(tx_o), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    lows = 0;
    repeat (100) begin @(negedge clk); if (tx_o !== 1'b1) lows++; end
    check("idle_low_cycles", 32'(lows), 32'd0);

    // Single byte 0xA5: exact waveform and busy timing
    push8(8'hA5, acc);
    n0 = acc;
    @(negedge clk);
    check("a5_pre_high", 32'(tx_o), 32'd1);
    check("a5_busy_on", 32'(busy), 32'd1);
    mism = 0;
    for (int t = 0; t < 10 * C8; t++) begin
      @(negedge clk);
      if (tx_o !== exp_bit(8'hA5, t, C8)) mism++;
      if (t == 10 * C8 - 1) check("a5_busy_last", 32'(busy), 32'd1);
    end
    check("a5_wave_mism", 32'(mism), 32'd0);
    @(negedge clk);
    check("a5_busy_fall_cycle", 32'(cyc), 32'(n0 + 82));
    check("a5_busy_off", 32'(busy), 32'd0);
    check("a5_post_high", 32'(tx_o), 32'd1);
    drain(1);

    // Burst of 5 on consecutive cycles, then full-FIFO contention with 0x11
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      push8(burst[i], acc);
      if (i == 0) n0 = acc;
    end
    check("burst_full_ready", 32'(tx_ready), 32'd0);
    check("burst_last_acc", 32'(acc), 32'(n0 + 4));
    push8(8'h11, acc11);
    check("contend_acc", 32'(acc11), 32'(n0 + 2 + 10 * C8));
    drain(6);
    check("burst_span", 32'(prev_start + 10 * C8 - (n0 + 2)), 32'(60 * C8));

    // Reset during data bit 3 of 0x5A with two bytes queued
    repeat (5) @(negedge clk);
    push8(8'h5A, acc);
    n0 = acc;
    push8(8'h12, acc);
    push8(8'h34, acc);
    target = n0 + 2 + 4 * C8 + 2;
    while (cyc < target) @(negedge clk);
    check("midframe_bit3", 32'(tx_o), 32'(exp_bit(8'h5A, 4 * C8 + 2, C8)));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx_o", 32'(tx_o), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(tx_ready), 32'd1);
    exp_byte_q.delete();
    exp_acc_q.delete();
    prev_start = -1000000;
    lows = 0;
    repeat (200) begin @(negedge clk); if (tx_o !== 1'b1) lows++; end
    check("midrst_quiet", 32'(lows), 32'd0);
    check("midrst_no_rx", 32'(rx_byte_q.size()), 32'd0);
    check("midrst_busy_later", 32'(busy), 32'd0);

    // Randomized traffic with random gaps
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 150)) @(negedge clk);
      push8(8'($urandom_range(0, 255)), acc);
    end
    drain(14);

    // Default CLKS_PER_BIT instance: every bit exactly 4167 cycles
    d_data = 8'h5A;
    d_valid = 1'b1;
    check("d_ready", 32'(d_ready), 32'd1);
    @(negedge clk);
    acc = cyc;
    d_valid = 1'b0;
    @(negedge clk);
    check("d_pre_high", 32'(d_tx_o), 32'd1);
    mism = 0;
    for (int t = 0; t < 10 * CD; t++) begin
      @(negedge clk);
      if (d_tx_o !== exp_bit(8'h5A, t, CD)) mism++;
    end
    check("d_wave_mism", 32'(mism), 32'd0);
    @(negedge clk);
    check("d_post_high", 32'(d_tx_o), 32'd1);
    check("d_busy_off", 32'(d_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/user_uart_tx.md
# user_uart_tx

Byte-serial UART transmitter for the user project area, driving an 8N1 serial line onto a user GPIO pad, typically `mprj_io[6]`, the line the testbench UART monitors. Firmware-side or user-logic producers push bytes through a valid/ready port into a small FIFO. A baud-timed shift state machine serialises them LSB-first with no idle gap between queued bytes. It is the transmit counterpart of the bench UART receiver and carries status and latency reports out of the FIR user design.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 4167: clock cycles per serial bit (40 MHz / 9600 baud). Legal range is ≥ 2.
- `FIFO_DEPTH`, default 4: byte entries. Must be a power of two, ≥ 2.

Ports:
- `wb_clk_i`  in  1  sole clock; all logic on rising edge
- `wb_rst_i`  in  1  synchronous, active-high reset
- `tx_data`  in  8  byte to send
- `tx_valid`  in  1  producer offers `tx_data`
- `tx_ready`  out  1  FIFO can accept; a byte is accepted on an edge where `tx_valid & tx_ready`
- `tx_o`  out  1  serial line; idles high
- `tx_oeb`  out  1  pad output-enable, active low
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty

## Operation
- Frame is 8N1: one start bit (0), data bits 0..7 LSB-first, one stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
- FIFO:
  - Circular buffer with write pointer, read pointer, and an occupancy count of width clog2(`FIFO_DEPTH`)+1.
  - `tx_ready = (count != FIFO_DEPTH)`, decoded from registered count only; it does not depend on a same-cycle pop.
  - When full, a `tx_valid` offer is not accepted even if a pop happens that cycle.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- State machine with states IDLE, START, DATA, STOP:
  - IDLE: `tx_o`=1. If count≠0, pop the head into the shift register, clear the baud counter, and go to START.
  - START: `tx_o`=0. When the baud counter reaches `CLKS_PER_BIT`-1, clear it, clear the bit index, and go to DATA.
  - DATA: `tx_o`=shift[0]. At each bit end, shift right. When bit index = 7 at bit end, go to STOP; otherwise increment the index.
  - STOP: `tx_o`=1. At bit end, if count≠0, pop and go directly to START (no idle cycle); else go to IDLE.
- `busy = (state != IDLE) | (count != 0)`.
- `tx_oeb` is 0 whenever not in reset.
- `tx_o` is a registered output and never glitches.

## Timing
- Reset values:
  - `tx_o`=1, `tx_oeb`=1 during the reset cycle and 0 from the first edge after deassertion.
  - `tx_ready`=1, `busy`=0, state=IDLE, count=0, pointers=0, baud counter=0, bit index=0.
- Latency from idle: if a byte is accepted at edge N, the pop occurs at edge N+1, and `tx_o` falls at edge N+2.
- Frame length: 10×`CLKS_PER_BIT` cycles from the start-bit falling edge to the end of the stop bit.
- Back-to-back bytes: the next start bit begins on the cycle immediately after the last stop-bit cycle. The continuous stream carries no gap cycles.
- Throughput: one byte per 10×`CLKS_PER_BIT` cycles. `tx_ready` returns high on the edge after a pop from a full FIFO.
- Reset mid-frame (synchronous):
  - On the reset edge, `tx_o` returns to 1, the FIFO is emptied, and the partial frame is abandoned.
  - No stop bit is emitted for the abandoned frame.
- `tx_valid` while `tx_ready`=0: the data is ignored; the producer must hold it.

## Test plan
- Reset and idle, with `CLKS_PER_BIT`=8: hold `wb_rst_i` 3 cycles, then release → `tx_o`=1, `tx_ready`=1, `busy`=0, `tx_oeb` 1 during reset and 0 after; `tx_o` stays high for 100 cycles with no push.
- Single byte 0xA5 accepted at edge N → `tx_o` low at N+2 for 8 cycles. Bits then read 1,0,1,0,0,1,0,1 at 8 cycles each, followed by a stop high for 8 cycles. `busy` falls at N+82 and a bench receiver decodes 0xA5.
- Burst 0xA5, 0x5A, 0x00, 0xFF, 0x3C pushed on consecutive cycles (depth 4):
  - `tx_ready` drops after the FIFO fills; the 5th byte is accepted after the first pop.
  - The receiver decodes all 5 bytes in order.
  - No idle-high gap appears between a stop bit and the next start bit; total line activity is 400 cycles.
- Full-FIFO contention: with count=4, hold `tx_valid` with 0x11 across the pop cycle → not accepted on that edge, accepted on the next edge; no byte is lost or duplicated.
- Reset mid-frame: assert reset during data bit 3 of 0x5A with 2 bytes queued → `tx_o`=1 next edge, `busy`=0, `tx_ready`=1; no further transitions for 200 cycles.
- Default parameter: `CLKS_PER_BIT`=4167, send 0x5A → each bit measures exactly 4167 cycles (104175 ns at a 25 ns clock).
